// File: rtl/uart_tx_feeder_if.sv
// uart_tx_feeder_if: byte stream with valid/ready handshake
interface uart_tx_feeder_if;
  logic [7:0] data;
  logic valid;
  logic ready;
  modport master(output data, valid, input ready);
  modport slave(input data, valid, output ready);
endinterface

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: byte FIFO and launch sequencer feeding a uart_tx that does not latch its data
module uart_tx_feeder #(
  parameter int ADDR_W = 4,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic clk,
  input  logic rst,
  uart_tx_feeder_if.slave src,
  output logic [7:0] tx_data,
  output logic tx_pluse,
  input  logic tx_busy,
  output logic [ADDR_W:0] fifo_count,
  output logic idle,
  output logic err_no_ack
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CW = $clog2(ACK_TIMEOUT);
  typedef enum logic [2:0] {IDLE, LOAD, PULSE, WAIT_ACK, WAIT_DONE} state_t;
  state_t state, next;
  logic [7:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] ack_cnt;
  logic push, pop, ack_done;
  assign src.ready = fifo_count != (ADDR_W+1)'(DEPTH);
  assign push = src.valid & src.ready;
  assign pop = state == LOAD;
  assign ack_done = ack_cnt == CW'(ACK_TIMEOUT - 1);
  assign idle = fifo_count == '0 && state == IDLE;
  always_comb begin
    next = IDLE;
    case (state)
      IDLE:      next = (fifo_count != '0 && !tx_busy) ? LOAD : IDLE;
      LOAD:      next = PULSE;
      PULSE:     next = WAIT_ACK;
      WAIT_ACK:  next = tx_busy ? WAIT_DONE : ack_done ? IDLE : WAIT_ACK;
      WAIT_DONE: next = tx_busy ? WAIT_DONE : IDLE;
      default:   next = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= src.data;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_count <= '0;
      tx_data <= 8'h00;
      tx_pluse <= 1'b0;
      ack_cnt <= '0;
      err_no_ack <= 1'b0;
    end else begin
      state <= next;
      tx_pluse <= next == PULSE;
      ack_cnt <= state == WAIT_ACK ? ack_cnt + 1'b1 : '0;
      fifo_count <= fifo_count + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        tx_data <= mem[rd_ptr];
      end
      if (state == WAIT_ACK && !tx_busy && ack_done) err_no_ack <= 1'b1;
    end
  end
endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb_uart_tx_feeder: scoreboard bench with a behavioural uart_tx (BPS_NUM=4) sampling tx_data live
module tb_uart_tx_feeder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] tx_data;
  logic tx_pluse, tx_busy, idle, err_no_ack;
  logic [4:0] fifo_count;
  uart_tx_feeder_if src();
  uart_tx_feeder #(.ADDR_W(4), .ACK_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .src(src), .tx_data(tx_data), .tx_pluse(tx_pluse),
    .tx_busy(tx_busy), .fifo_count(fifo_count), .idle(idle), .err_no_ack(err_no_ack)
  );
  always #5 clk = ~clk;
  int total = 0;
  int bad = 0;
  int frames = 0;
  int viol = 0;
  logic [7:0] q[$];
  logic hold = 1'b0, uart_en = 1'b1, skip = 1'b0, nosb = 1'b0;
  logic mbusy = 1'b0, chg = 1'b0, line;
  logic [3:0] bitn = 4'd0;
  logic [1:0] ph = 2'd0;
  logic [9:0] fbits = '0, last_frame = '0;
  logic [7:0] ref_data = 8'h00, e;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  assign tx_busy = mbusy | hold;
  assign line = bitn == 4'd0 ? 1'b0 : bitn == 4'd9 ? 1'b1 : tx_data[3'(bitn - 4'd1)];
  // uart_tx stand-in: start, 8 data bits LSB first read from tx_data as they go, stop
  always @(posedge clk) begin
    if (tx_pluse && tx_busy) viol++;
    if (!mbusy) begin
      if (uart_en && tx_pluse) begin
        mbusy <= 1'b1;
        bitn <= 4'd0;
        ph <= 2'd0;
        ref_data <= tx_data;
        chg <= 1'b0;
      end
    end else begin
      if (tx_data !== ref_data) chg <= 1'b1;
      if (ph == 2'd0) fbits[bitn] <= line;
      ph <= ph + 2'd1;
      if (ph == 2'd3) begin
        bitn <= bitn + 4'd1;
        if (bitn == 4'd9) begin
          mbusy <= 1'b0;
          frames++;
          last_frame <= fbits;
          if (!skip) begin
            check("sb_nonempty", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) begin
              e = q.pop_front();
              check("frame", 32'(fbits), 32'({1'b1, e, 1'b0}));
            end
            check("stable", 32'(chg | (tx_data !== ref_data)), 32'd0);
          end
        end
      end
    end
  end
  always @(posedge clk)
    if (!rst && src.valid && src.ready && !nosb) q.push_back(src.data);
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic push_byte(input logic [7:0] d);
    int n = 0;
    src.data = d;
    src.valid = 1'b1;
    while (!src.ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("push_timeout", 32'(n >= 50), 32'd0);
    @(negedge clk);
  endtask
  task automatic wait_idle(input int lim);
    int n = 0;
    while (!(idle && !tx_busy) && n < lim) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 32'(n >= lim), 32'd0);
  endtask
  initial begin
    #3_000_000;
    $display("FAIL watchdog got=hang exp=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int f0, n, incr;
    logic [4:0] prev;
    src.valid = 1'b0;
    src.data = 8'h00;
    cyc(3);
    check("rst_ready", 32'(src.ready), 32'd1);
    check("rst_data", 32'(tx_data), 32'h00);
    check("rst_pulse", 32'(tx_pluse), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_idle", 32'(idle), 32'd1);
    check("rst_err", 32'(err_no_ack), 32'd0);
    rst = 1'b0;
    cyc(1);
    // single byte latency and serial waveform
    push_byte(8'hA5);
    src.valid = 1'b0;
    check("lat_e0", 32'(tx_pluse), 32'd0);
    cyc(1);
    check("lat_e1", 32'(tx_pluse), 32'd0);
    cyc(1);
    check("lat_e2", 32'(tx_pluse), 32'd1);
    check("lat_data", 32'(tx_data), 32'hA5);
    cyc(1);
    check("lat_e3", 32'(tx_pluse), 32'd0);
    wait_idle(200);
    check("a5_line", 32'(last_frame), 32'b1101001010);
    check("a5_idle", 32'(idle), 32'd1);
    // fill to full while the uart is held busy
    hold = 1'b1;
    f0 = frames;
    for (int i = 0; i < 16; i++) push_byte(8'(i));
    src.data = 8'h10;
    check("full_ready", 32'(src.ready), 32'd0);
    cyc(3);
    check("full_count", 32'(fifo_count), 32'd16);
    check("full_ready2", 32'(src.ready), 32'd0);
    src.valid = 1'b0;
    hold = 1'b0;
    n = 0;
    incr = 0;
    prev = fifo_count;
    while (!(idle && !tx_busy) && n < 2000) begin
      @(negedge clk);
      if (fifo_count > prev) incr++;
      prev = fifo_count;
      n++;
    end
    check("drain_timeout", 32'(n >= 2000), 32'd0);
    check("drain_mono", 32'(incr), 32'd0);
    check("drain_frames", 32'(frames - f0), 32'd16);
    check("drain_count", 32'(fifo_count), 32'd0);
    // push and pop in the same cycle at count 5
    hold = 1'b1;
    f0 = frames;
    for (int i = 0; i < 5; i++) push_byte(8'h20 + 8'(i));
    src.valid = 1'b0;
    check("pp_pre", 32'(fifo_count), 32'd5);
    hold = 1'b0;
    cyc(1);
    push_byte(8'h25);
    src.valid = 1'b0;
    check("pp_count", 32'(fifo_count), 32'd5);
    wait_idle(1000);
    check("pp_frames", 32'(frames - f0), 32'd6);
    // no acknowledge from the uart
    uart_en = 1'b0;
    nosb = 1'b1;
    push_byte(8'h3C);
    src.valid = 1'b0;
    n = 0;
    while (!tx_pluse && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("na_pulse", 32'(tx_pluse), 32'd1);
    cyc(4);
    check("na_err_early", 32'(err_no_ack), 32'd0);
    cyc(1);
    check("na_err", 32'(err_no_ack), 32'd1);
    check("na_idle", 32'(idle), 32'd1);
    check("na_count", 32'(fifo_count), 32'd0);
    cyc(10);
    check("na_sticky", 32'(err_no_ack), 32'd1);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    check("na_clear", 32'(err_no_ack), 32'd0);
    uart_en = 1'b1;
    nosb = 1'b0;
    // reset in the middle of a frame
    push_byte(8'hFF);
    src.valid = 1'b0;
    n = 0;
    while (!tx_busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("mr_busy", 32'(tx_busy), 32'd1);
    for (int i = 0; i < 3; i++) push_byte(8'h51 + 8'(i));
    src.valid = 1'b0;
    check("mr_queued", 32'(fifo_count), 32'd3);
    cyc(5);
    skip = 1'b1;
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    q.delete();
    check("mr_count", 32'(fifo_count), 32'd0);
    check("mr_pulse", 32'(tx_pluse), 32'd0);
    check("mr_data", 32'(tx_data), 32'h00);
    check("mr_uart_busy", 32'(tx_busy), 32'd1);
    push_byte(8'h77);
    src.valid = 1'b0;
    n = 0;
    incr = 0;
    while (tx_busy && n < 100) begin
      @(negedge clk);
      if (tx_pluse) incr++;
      n++;
    end
    check("mr_hold_off", 32'(incr), 32'd0);
    check("mr_end", 32'(tx_busy), 32'd0);
    skip = 1'b0;
    wait_idle(200);
    check("mr_after", 32'(fifo_count), 32'd0);
    // back-to-back burst with stability checked per frame
    f0 = frames;
    push_byte(8'h81);
    push_byte(8'h42);
    push_byte(8'hC3);
    push_byte(8'h18);
    src.valid = 1'b0;
    wait_idle(1000);
    check("burst_frames", 32'(frames - f0), 32'd4);
    check("pulse_busy", 32'(viol), 32'd0);
    check("sb_left", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
